// File: rtl/id_ex_stage_pkg.sv
// id_ex_stage_pkg: pipeline control encoding shared by decoder, ID/EX and EX/MEM
package id_ex_stage_pkg;
  localparam logic [1:0] ALU_OP_RTYPE = 2'b00;
  localparam logic [1:0] ALU_OP_ADD   = 2'b01;
  localparam logic [1:0] ALU_OP_SUB   = 2'b10;
  typedef struct packed {
    logic       regDst;
    logic       aluSrc;
    logic       memToReg;
    logic       regWrite;
    logic       memWrite;
    logic       branch;
    logic       jump;
    logic       extOp;
    logic       memRead;
    logic [1:0] aluOp;
  } ctrl_t;
  localparam ctrl_t CTRL_BUBBLE = '0;
endpackage

// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if: decode-side inputs and execute-side outputs of the ID/EX boundary
interface id_ex_stage_if #(parameter int DATA_W = 32, parameter int REG_AW = 5);
  logic              id_valid;
  logic              id_reg_dst, id_alu_src, id_mem_to_reg, id_reg_write, id_mem_write;
  logic              id_branch, id_jump, id_ext_op, id_mem_read;
  logic [1:0]        id_alu_op;
  logic [DATA_W-1:0] id_pc_plus4, id_rs_data, id_rt_data;
  logic [15:0]       id_imm16;
  logic [REG_AW-1:0] id_rs, id_rt, id_rd;
  logic              flush;
  logic              stall;
  logic              ex_valid;
  logic              ex_reg_dst, ex_alu_src, ex_mem_to_reg, ex_reg_write, ex_mem_write;
  logic              ex_branch, ex_jump, ex_ext_op, ex_mem_read;
  logic [1:0]        ex_alu_op;
  logic [DATA_W-1:0] ex_pc_plus4, ex_rs_data, ex_rt_data, ex_imm;
  logic [REG_AW-1:0] ex_rs, ex_rt, ex_rd;
  modport master (
    output id_valid, id_reg_dst, id_alu_src, id_mem_to_reg, id_reg_write, id_mem_write,
           id_branch, id_jump, id_ext_op, id_mem_read, id_alu_op, id_pc_plus4,
           id_rs_data, id_rt_data, id_imm16, id_rs, id_rt, id_rd, flush,
    input  stall, ex_valid, ex_reg_dst, ex_alu_src, ex_mem_to_reg, ex_reg_write,
           ex_mem_write, ex_branch, ex_jump, ex_ext_op, ex_mem_read, ex_alu_op,
           ex_pc_plus4, ex_rs_data, ex_rt_data, ex_imm, ex_rs, ex_rt, ex_rd
  );
  modport slave (
    input  id_valid, id_reg_dst, id_alu_src, id_mem_to_reg, id_reg_write, id_mem_write,
           id_branch, id_jump, id_ext_op, id_mem_read, id_alu_op, id_pc_plus4,
           id_rs_data, id_rt_data, id_imm16, id_rs, id_rt, id_rd, flush,
    output stall, ex_valid, ex_reg_dst, ex_alu_src, ex_mem_to_reg, ex_reg_write,
           ex_mem_write, ex_branch, ex_jump, ex_ext_op, ex_mem_read, ex_alu_op,
           ex_pc_plus4, ex_rs_data, ex_rt_data, ex_imm, ex_rs, ex_rt, ex_rd
  );
endinterface

// File: rtl/id_ex_stage_hazard_detect.sv
// hazard_detect: load-use detection between the load in EX and the instruction in ID
module hazard_detect #(parameter int REG_AW = 5) (
  input  logic              exValid,
  input  logic              exMemRead,
  input  logic [REG_AW-1:0] exRt,
  input  logic              idValid,
  input  logic              idJump,
  input  logic              idRegDst,
  input  logic              idBranch,
  input  logic              idMemWrite,
  input  logic [REG_AW-1:0] idRs,
  input  logic [REG_AW-1:0] idRt,
  input  logic              flush,
  output logic              stall,
  output logic              hz
);
  logic usesRs, usesRt;
  assign usesRs = idValid & ~idJump;
  assign usesRt = idValid & (idRegDst | idBranch | idMemWrite);
  assign hz = exValid & exMemRead & (exRt != '0) &
              ((usesRs & (exRt == idRs)) | (usesRt & (exRt == idRt)));
  assign stall = hz & ~flush;
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with immediate extension, load-use bubble and flush
module id_ex_stage
  import id_ex_stage_pkg::*;
#(parameter int DATA_W = 32, parameter int REG_AW = 5) (
  input logic          clk,
  input logic          rst_n,
  id_ex_stage_if.slave bus
);
  logic              hz, bubble, exValid;
  logic [DATA_W-1:0] immExt;
  ctrl_t             idCtrl, nextCtrl, exCtrl;
  logic [DATA_W-1:0] exPcPlus4, exRsData, exRtData, exImm;
  logic [REG_AW-1:0] exRs, exRt, exRd;
  hazard_detect #(.REG_AW(REG_AW)) uHazard (
    .exValid(exValid), .exMemRead(exCtrl.memRead), .exRt(exRt),
    .idValid(bus.id_valid), .idJump(bus.id_jump), .idRegDst(bus.id_reg_dst),
    .idBranch(bus.id_branch), .idMemWrite(bus.id_mem_write),
    .idRs(bus.id_rs), .idRt(bus.id_rt), .flush(bus.flush),
    .stall(bus.stall), .hz(hz)
  );
  assign bubble = bus.flush | hz;
  assign immExt = bus.id_ext_op ? {{(DATA_W-16){bus.id_imm16[15]}}, bus.id_imm16}
                                : {{(DATA_W-16){1'b0}}, bus.id_imm16};
  // jump leaves the decoder's ALU class undefined, so it is pinned to R-type
  assign idCtrl = '{regDst: bus.id_reg_dst, aluSrc: bus.id_alu_src,
                    memToReg: bus.id_mem_to_reg, regWrite: bus.id_reg_write,
                    memWrite: bus.id_mem_write, branch: bus.id_branch,
                    jump: bus.id_jump, extOp: bus.id_ext_op, memRead: bus.id_mem_read,
                    aluOp: bus.id_jump ? ALU_OP_RTYPE : bus.id_alu_op};
  assign nextCtrl = (bubble | ~bus.id_valid) ? CTRL_BUBBLE : idCtrl;
  // pipeline register: capture decode, or insert a cleared bubble on flush/hazard
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exValid   <= 1'b0;
      exCtrl    <= CTRL_BUBBLE;
      exPcPlus4 <= '0;
      exRsData  <= '0;
      exRtData  <= '0;
      exImm     <= '0;
      exRs      <= '0;
      exRt      <= '0;
      exRd      <= '0;
    end else begin
      exValid   <= bus.id_valid & ~bubble;
      exCtrl    <= nextCtrl;
      exPcPlus4 <= bubble ? '0 : bus.id_pc_plus4;
      exRsData  <= bubble ? '0 : bus.id_rs_data;
      exRtData  <= bubble ? '0 : bus.id_rt_data;
      exImm     <= bubble ? '0 : immExt;
      exRs      <= bubble ? '0 : bus.id_rs;
      exRt      <= bubble ? '0 : bus.id_rt;
      exRd      <= bubble ? '0 : bus.id_rd;
    end
  end
  assign bus.ex_valid      = exValid;
  assign bus.ex_reg_dst    = exCtrl.regDst;
  assign bus.ex_alu_src    = exCtrl.aluSrc;
  assign bus.ex_mem_to_reg = exCtrl.memToReg;
  assign bus.ex_reg_write  = exCtrl.regWrite;
  assign bus.ex_mem_write  = exCtrl.memWrite;
  assign bus.ex_branch     = exCtrl.branch;
  assign bus.ex_jump       = exCtrl.jump;
  assign bus.ex_ext_op     = exCtrl.extOp;
  assign bus.ex_mem_read   = exCtrl.memRead;
  assign bus.ex_alu_op     = exCtrl.aluOp;
  assign bus.ex_pc_plus4   = exPcPlus4;
  assign bus.ex_rs_data    = exRsData;
  assign bus.ex_rt_data    = exRtData;
  assign bus.ex_imm        = exImm;
  assign bus.ex_rs         = exRs;
  assign bus.ex_rt         = exRt;
  assign bus.ex_rd         = exRd;
endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline boundary of the five-stage MIPS pipeline. Captures the main decoder's control signals together with decode-stage operands and register specifiers, and presents them to the execute stage one cycle later. It contains the load-use hazard detector: it stalls PC and IF/ID and inserts a bubble. It also squashes the decode-stage instruction on a flush from branch/jump resolution.

## Interface
Parameters:
- DATA_W, 32, datapath width (PC, register operands, extended immediate)
- REG_AW, 5, register-specifier width

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- id_valid  in  1  decode stage holds a real instruction
- id_reg_dst, id_alu_src, id_mem_to_reg, id_reg_write, id_mem_write, id_branch, id_jump, id_ext_op, id_mem_read  in  1 each  decoder control outputs
- id_alu_op  in  2  decoder ALU class: 00 R-type funct, 01 add, 10 sub
- id_pc_plus4  in  DATA_W  PC+4 of decode instruction
- id_rs_data, id_rt_data  in  DATA_W  register-file read data
- id_imm16  in  16  instruction[15:0]
- id_rs, id_rt, id_rd  in  REG_AW  instruction register fields
- flush  in  1  squash decode instruction (taken branch/jump)
- stall  out  1  hold PC and IF/ID this cycle (combinational)
- ex_valid  out  1  execute stage holds a real instruction
- ex_reg_dst … ex_mem_read, ex_alu_op  out  same widths  registered control
- ex_pc_plus4, ex_rs_data, ex_rt_data, ex_imm  out  DATA_W  registered data; ex_imm extended
- ex_rs, ex_rt, ex_rd  out  REG_AW  registered specifiers (for forwarding and write-back select)

## Operation
- Immediate extension, before capture: id_ext_op=1 → sign-extend imm16 to DATA_W. id_ext_op=0 → zero-extend.
- Operand usage: uses_rs = id_valid & ~id_jump; uses_rt = id_valid & (id_reg_dst | id_branch | id_mem_write).
- Load-use hazard: hz = ex_valid & ex_mem_read & (ex_rt≠0) & ((uses_rs & ex_rt==id_rs) | (uses_rt & ex_rt==id_rt)).
- stall = hz & ~flush.
- Per-cycle update, priority flush > hazard > normal:
  - flush=1: bubble. ex_valid=0; all control zero; ex_alu_op=00; data/specifier fields don't-care, implemented as cleared.
  - hz=1: bubble as above. The ID instruction is retained upstream by stall.
  - otherwise: capture every id_* field. ex_valid=id_valid.
  - id_valid=0 and no flush/hazard: captured with all control forced to zero.
- Jump: the decoder's ALUOp is undefined for jump and is registered as 00. All other jump controls pass through, except ex_jump=1.
- Bubble invariant: ex_valid=0 implies ex_reg_write=ex_mem_write=ex_mem_read=ex_branch=ex_jump=0.

## Timing
- Reset (rst_n low, asynchronous): all ex_* outputs 0, ex_valid 0. stall is consequently 0.
- Latency: one cycle from id_* to ex_*.
- stall is same-cycle combinational from current ex_* registers and id_* inputs. There is no flop inside the stall path.
- Load-use produces exactly one bubble. The next cycle ex_mem_read=0, so stall drops and the held instruction advances.
- Back-to-back lw followed by dependent lw: one bubble per dependency, never two consecutive for one pair.
- Simultaneous flush and hazard: flush wins, stall=0, one bubble.
- Reset deassertion mid-stream: first captured edge after release behaves as normal with empty EX (no hazard possible).
- Register $0 as ex_rt never stalls.

## Structure
- Shared pipeline package: ALU_OP_RTYPE=2'b00, ALU_OP_ADD=2'b01, ALU_OP_SUB=2'b10. Also a packed control struct ctrl_t holding the nine 1-bit controls plus alu_op, shared with decoder and EX/MEM stage. Also the constant CTRL_BUBBLE (all zero).
- One sub-module: hazard_detect (combinational: ex_mem_read, ex_rt, ex_valid, id fields, flush → stall, hz).
- Top holds the extension logic and the pipeline register with async reset.

## Test plan
- Reset: assert rst_n=0 mid-stream with ex_reg_write=1 → all ex_* 0 and stall 0 immediately, without waiting for clk.
- Pass-through: addi, imm16=16'hFFFF, ext_op=0 → ex_imm=32'h0000FFFF next cycle. lw with imm16=16'hFFFC, ext_op=1 → ex_imm=32'hFFFFFFFC, ex_mem_read=1, ex_alu_op=01.
- Load-use: lw $8 then add $9,$8,$10 → stall=1 for one cycle. A bubble appears in EX (ex_valid=0, ex_reg_write=0), then add enters EX with ex_rs=8.
- No false hazard: lw $0 then add using $0 → stall never asserts. lw $8 then addi $8,$3,1 (rt is dest) → no stall.
- Flush: flush=1 with beq in ID → ex_valid=0 and controls zero next cycle. Flush coincident with a load-use condition → stall=0, single bubble.
- Jump: id_jump=1, id_alu_op=2'bxx → ex_jump=1, ex_alu_op=00, ex_reg_write=0.
